stratixii_muxn_reg: RTL and testbench
=====================================

STRATIXII_MUXN_REG -- requirements
Module: stratixii_muxn_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per input channel, legal 1..64.
REQ-002 SHALL have parameter NUM_IN, default 4: channel count, legal 2..16.
REQ-003 SHALL have parameter MODE, default "SELECT": "SELECT" (S-steered) or "ROUND_ROBIN" (rotating fair pick).
REQ-004 SHALL derive SEL_W = max(1, clog2(NUM_IN)); SEL_W is not user-settable.
REQ-005 SHALL have port CLK  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port SCLR  input  1  synchronous, active-high reset.
REQ-007 SHALL have port ENA  input  1  clock enable; 0 freezes all state.
REQ-008 SHALL have port IN  input  NUM_IN*WIDTH  channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port IN_VALID  input  NUM_IN  per-channel data-valid.
REQ-010 SHALL have port IN_READY  output  NUM_IN  per-channel accept.
REQ-011 SHALL have port S  input  SEL_W  channel select; used only in MODE "SELECT".
REQ-012 SHALL have port MO  output  WIDTH  registered output data.
REQ-013 SHALL have port MO_VALID  output  1  MO holds an unconsumed word.
REQ-014 SHALL have port MO_READY  input  1  downstream accept.
REQ-015 SHALL have port MO_SEL  output  SEL_W  index of the channel that produced MO.

Function
REQ-016 SHALL hold one output slot; slot is free when MO_VALID=0 or MO_READY=1 in the same cycle.
REQ-017 SHALL choose candidate channel c combinationally: SELECT mode c=S; S>=NUM_IN means no candidate.
REQ-018 SHALL, in ROUND_ROBIN mode, take c as the first index with IN_VALID=1, searching upward from PTR+1 and wrapping modulo NUM_IN; no candidate if IN_VALID=0.
REQ-019 SHALL drive IN_READY[c]=1 only when ENA=1, SCLR=0, a candidate exists and the slot is free; all other IN_READY bits SHALL be 0.
REQ-020 SHALL transfer when IN_VALID[c]&IN_READY[c]: next edge loads MO=IN[c], MO_SEL=c, MO_VALID=1.
REQ-021 SHALL have latency one cycle, IN transfer to MO_VALID; throughput one word per cycle with MO_READY held 1.
REQ-022 SHALL clear MO_VALID on an edge where MO_VALID&MO_READY and no new transfer occurs; simultaneous drain and load SHALL leave MO_VALID=1 with the new word.
REQ-023 SHALL hold MO, MO_SEL and MO_VALID stable while MO_VALID=1 and MO_READY=0.
REQ-024 SHALL, in ROUND_ROBIN mode, update PTR to c only on a transfer; PTR is unchanged otherwise.
REQ-025 SHALL keep all state frozen and IN_READY all 0 while ENA=0, regardless of MO_READY.
REQ-026 SHALL ignore S changes except in the cycle of a transfer; the word in the slot is not altered.

Reset
REQ-027 SHALL, on a rising edge with SCLR=1, set MO=0, MO_SEL=0, MO_VALID=0 and PTR=NUM_IN-1, so channel 0 wins first.
REQ-028 SHALL give SCLR priority over ENA and over any concurrent transfer; a word in the slot is discarded.
REQ-029 SHALL drive IN_READY all 0 while SCLR=1.

Structure
REQ-030 SHALL place the MODE string constants and the clog2 function in shared package stratixii_mux_pkg.
REQ-031 SHALL implement the rotating search in sub-module stratixii_rr_pick (inputs: request vector, PTR; outputs: index, found). SELECT mode SHALL leave it unused.
REQ-032 SHALL contain no latches; only the output slot and PTR are registered.

Verification
REQ-033 SHALL test SELECT, WIDTH=8, NUM_IN=4, S=2, IN_VALID=4'b0100, IN[23:16]=8'hA5, MO_READY=1: IN_READY=4'b0100, and next cycle MO=8'hA5, MO_SEL=2, MO_VALID=1.
REQ-034 SHALL test backpressure with MO_VALID=1, MO_READY=0 for 3 cycles: IN_READY=0, and MO/MO_SEL unchanged. When MO_READY rises, the pending word transfers the same cycle.
REQ-035 SHALL test ROUND_ROBIN with IN_VALID=4'b1111 held and MO_READY=1 after reset: MO_SEL sequence is 0,1,2,3,0.
REQ-036 SHALL test ROUND_ROBIN wrap skip with IN_VALID=4'b1001 and PTR=0: grant 3, then 0, then 3.
REQ-037 SHALL test SCLR asserted while MO_VALID=1 and a transfer is pending: next cycle MO_VALID=0, MO=0, and the next grant is channel 0.
REQ-038 SHALL test ENA=0 for 2 cycles with valid inputs and MO_READY=1: IN_READY=0, and no output change.

Source files
------------

// File: rtl/stratixii_mux_pkg.sv
// Shared constants and elaboration-time helpers for the registered N-way mux.
package stratixii_mux_pkg;

    localparam string MODE_SELECT      = "SELECT";
    localparam string MODE_ROUND_ROBIN = "ROUND_ROBIN";

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int selWidth(input int n);
        return (clog2(n) > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stratixii_rr_pick.sv
// Rotating search: first requesting index strictly after ptr_i, wrapping around.
module stratixii_rr_pick #(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [SEL_W-1:0]  ptr_i,
    output logic [SEL_W-1:0]  idx_o,
    output logic              found_o
);

    // Walk from farthest to nearest so the nearest requester overwrites last.
    always_comb begin
        int cand;
        idx_o   = '0;
        found_o = 1'b0;
        cand    = 0;
        for (int k = NUM_IN; k >= 1; k--) begin
            cand = (int'(ptr_i) + k) % NUM_IN;
            if (req_i[cand]) begin
                idx_o   = SEL_W'(cand);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stratixii_muxn_reg.sv
// N-input mux with a single registered output slot and valid/ready handshakes,
// steered either by S or by a round-robin pointer.
module stratixii_muxn_reg
    import stratixii_mux_pkg::*;
#(
    parameter int    WIDTH  = 8,
    parameter int    NUM_IN = 4,
    parameter string MODE   = "SELECT",
    localparam int   SEL_W  = selWidth(NUM_IN)
) (
    input  logic                    CLK,
    input  logic                    SCLR,
    input  logic                    ENA,
    input  logic [NUM_IN*WIDTH-1:0] IN,
    input  logic [NUM_IN-1:0]       IN_VALID,
    output logic [NUM_IN-1:0]       IN_READY,
    input  logic [SEL_W-1:0]        S,
    output logic [WIDTH-1:0]        MO,
    output logic                    MO_VALID,
    input  logic                    MO_READY,
    output logic [SEL_W-1:0]        MO_SEL
);

    logic [WIDTH-1:0] mo_q, mo_d;
    logic [SEL_W-1:0] mo_sel_q, mo_sel_d;
    logic             mo_valid_q, mo_valid_d;

    logic [SEL_W-1:0] candIdx;
    logic             candOk;
    logic             slotFree;
    logic             grant;
    logic             transfer;

    if (MODE == MODE_ROUND_ROBIN) begin : gRr
        logic [SEL_W-1:0] ptr_q;
        logic [SEL_W-1:0] rrIdx;
        logic             rrFound;

        stratixii_rr_pick #(
            .NUM_IN (NUM_IN),
            .SEL_W  (SEL_W)
        ) uPick (
            .req_i   (IN_VALID),
            .ptr_i   (ptr_q),
            .idx_o   (rrIdx),
            .found_o (rrFound)
        );

        assign candIdx = rrIdx;
        assign candOk  = rrFound;

        // Reset to the last index so channel 0 is searched first.
        always_ff @(posedge CLK) begin
            if (SCLR) begin
                ptr_q <= SEL_W'(NUM_IN - 1);
            end else if (transfer) begin
                ptr_q <= candIdx;
            end
        end
    end else begin : gSel
        assign candIdx = S;
        assign candOk  = (int'(S) < NUM_IN);
    end

    assign slotFree = !mo_valid_q || MO_READY;
    assign grant    = ENA && !SCLR && candOk && slotFree;
    assign transfer = grant && IN_VALID[candIdx];

    always_comb begin
        IN_READY = '0;
        if (grant) begin
            IN_READY[candIdx] = 1'b1;
        end
    end

    // A load takes precedence over a drain so back-to-back words keep MO_VALID high.
    always_comb begin
        mo_d       = mo_q;
        mo_sel_d   = mo_sel_q;
        mo_valid_d = mo_valid_q;
        if (transfer) begin
            mo_d       = IN[int'(candIdx)*WIDTH +: WIDTH];
            mo_sel_d   = candIdx;
            mo_valid_d = 1'b1;
        end else if (MO_READY) begin
            mo_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (SCLR) begin
            mo_q       <= '0;
            mo_sel_q   <= '0;
            mo_valid_q <= 1'b0;
        end else if (ENA) begin
            mo_q       <= mo_d;
            mo_sel_q   <= mo_sel_d;
            mo_valid_q <= mo_valid_d;
        end
    end

    assign MO       = mo_q;
    assign MO_SEL   = mo_sel_q;
    assign MO_VALID = mo_valid_q;

endmodule

// File: tb/tb_stratixii_muxn_reg.sv
// Directed bench: a SELECT instance driven from a vector table and a
// ROUND_ROBIN instance exercised with hand-written sequences.
module tb_stratixii_muxn_reg;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            sclr;
    logic            ena;
    logic [N*W-1:0]  inBus;
    logic [N-1:0]    inValid;
    logic [SW-1:0]   sel;
    logic            moReady;

    logic [N-1:0]    selReady,   rrReady;
    logic [W-1:0]    selMo,      rrMo;
    logic            selMoValid, rrMoValid;
    logic [SW-1:0]   selMoSel,   rrMoSel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stratixii_muxn_reg #(.WIDTH(W), .NUM_IN(N), .MODE("SELECT")) selDut (
        .CLK(clk), .SCLR(sclr), .ENA(ena), .IN(inBus), .IN_VALID(inValid),
        .IN_READY(selReady), .S(sel), .MO(selMo), .MO_VALID(selMoValid),
        .MO_READY(moReady), .MO_SEL(selMoSel)
    );

    stratixii_muxn_reg #(.WIDTH(W), .NUM_IN(N), .MODE("ROUND_ROBIN")) rrDut (
        .CLK(clk), .SCLR(sclr), .ENA(ena), .IN(inBus), .IN_VALID(inValid),
        .IN_READY(rrReady), .S(sel), .MO(rrMo), .MO_VALID(rrMoValid),
        .MO_READY(moReady), .MO_SEL(rrMoSel)
    );

    typedef struct {
        logic       sclr;
        logic       ena;
        logic [1:0] s;
        logic [3:0] valid;
        logic       moReady;
        logic [3:0] expReady;
        logic       expValid;
        logic [7:0] expMo;
        logic [1:0] expSel;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        sclr    = v.sclr;
        ena     = v.ena;
        sel     = v.s;
        inValid = v.valid;
        moReady = v.moReady;
        #1;
    endtask

    task automatic checkRrGrant(input string name, input int exp);
        checkOutput({name, " ready"}, 32'(rrReady), 32'(4'b0001 << exp));
        tick();
        checkOutput({name, " sel"},   32'(rrMoSel),   32'(exp));
        checkOutput({name, " valid"}, 32'(rrMoValid), 32'd1);
        checkOutput({name, " data"},  32'(rrMo),      32'(inBus[exp*W +: W]));
    endtask

    initial begin
        int rrSeq[5];
        int wrapSeq[3];
        rrSeq   = '{0, 1, 2, 3, 0};
        wrapSeq = '{3, 0, 3};

        // Channel data: ch0=11, ch1=3C, ch2=A5, ch3=D4.
        inBus = 32'hD4A53C11;

        //           sclr ena s  valid    rdy  expRdy  V  MO     SEL
        vecs[0]  = '{1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
        vecs[1]  = '{1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2};
        vecs[2]  = '{1'b0, 1'b1, 2'd3, 4'b1000, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2};
        vecs[3]  = '{1'b0, 1'b1, 2'd3, 4'b1000, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2};
        vecs[4]  = '{1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h3C, 2'd1};
        vecs[5]  = '{1'b0, 1'b0, 2'd0, 4'b0001, 1'b1, 4'b0000, 1'b1, 8'h3C, 2'd1};
        vecs[6]  = '{1'b0, 1'b0, 2'd0, 4'b0001, 1'b1, 4'b0000, 1'b1, 8'h3C, 2'd1};
        vecs[7]  = '{1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0001, 1'b0, 8'h3C, 2'd1};
        vecs[8]  = '{1'b0, 1'b1, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 8'hD4, 2'd3};
        vecs[9]  = '{1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
        vecs[10] = '{1'b0, 1'b1, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'h11, 2'd0};
        vecs[11] = '{1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0};

        sclr = 1'b1; ena = 1'b1; sel = '0; inValid = '0; moReady = 1'b0;
        tick();
        tick();
        checkOutput("reset sel ready", 32'(selReady),   32'd0);
        checkOutput("reset sel valid", 32'(selMoValid), 32'd0);
        checkOutput("reset sel mo",    32'(selMo),      32'd0);
        checkOutput("reset sel msel",  32'(selMoSel),   32'd0);
        checkOutput("reset rr ready",  32'(rrReady),    32'd0);
        checkOutput("reset rr valid",  32'(rrMoValid),  32'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d ready", i), 32'(selReady), 32'(vecs[i].expReady));
            tick();
            checkOutput($sformatf("vec%0d valid", i), 32'(selMoValid), 32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d mo", i),    32'(selMo),      32'(vecs[i].expMo));
            checkOutput($sformatf("vec%0d msel", i),  32'(selMoSel),   32'(vecs[i].expSel));
        end

        // Round robin with every channel requesting.
        sclr = 1'b1; ena = 1'b1; inValid = '0; moReady = 1'b1;
        tick();
        sclr = 1'b0; inValid = 4'b1111;
        #1;
        for (int i = 0; i < 5; i++) begin
            checkRrGrant($sformatf("rr all %0d", i), rrSeq[i]);
        end

        // Pointer now at 0; only channels 0 and 3 request.
        inValid = 4'b1001;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkRrGrant($sformatf("rr wrap %0d", i), wrapSeq[i]);
        end

        // Clock enable low freezes everything, even with the consumer ready.
        ena = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("rr ena0 ready %0d", i), 32'(rrReady), 32'd0);
            tick();
            checkOutput($sformatf("rr ena0 valid %0d", i), 32'(rrMoValid), 32'd1);
            checkOutput($sformatf("rr ena0 sel %0d", i),   32'(rrMoSel),   32'd3);
            checkOutput($sformatf("rr ena0 mo %0d", i),    32'(rrMo),      32'hD4);
        end

        // Reset discards the held word and the concurrent transfer.
        ena = 1'b1; sclr = 1'b1;
        #1;
        checkOutput("rr sclr ready", 32'(rrReady), 32'd0);
        tick();
        checkOutput("rr sclr valid", 32'(rrMoValid), 32'd0);
        checkOutput("rr sclr mo",    32'(rrMo),      32'd0);
        sclr = 1'b0; inValid = 4'b1111;
        #1;
        checkRrGrant("rr post sclr", 0);

        // No requesters: nothing granted, the held word drains.
        inValid = 4'b0000;
        #1;
        checkOutput("rr idle ready", 32'(rrReady), 32'd0);
        tick();
        checkOutput("rr idle valid", 32'(rrMoValid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
